// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and the rotating priority scan for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

    localparam int unsigned NReq = 8;
    localparam int unsigned IdxW = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRelease = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic            found;
        logic [IdxW-1:0] idx;
    } scan_t;

    // Rotate so bit ptr lands at position 0, find the lowest set bit, then add ptr back (mod 8).
    function automatic scan_t rr_scan(input logic [NReq-1:0] req, input logic [IdxW-1:0] ptr);
        logic [2*NReq-1:0] dbl;
        logic [NReq-1:0]   rot;
        scan_t             res;
        dbl = {req, req};
        rot = NReq'(dbl >> ptr);
        res = '0;
        for (int i = int'(NReq) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                res.found = 1'b1;
                res.idx   = ptr + IdxW'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_3x8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module decoder_3x8 (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a hold timeout; the grant vector is formed
// only by the shared decoder from the registered owner index and valid flag.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    if (MAX_HOLD < 2 || (MAX_HOLD - 1) >= (1 << HOLD_W)) begin : g_bad_param
        $error("rr_arbiter_8: MAX_HOLD must be >= 2 and MAX_HOLD-1 must fit in HOLD_W bits");
    end

    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

    arb_state_e       state_q;
    logic [IdxW-1:0]  ptr_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    scan_t            win;

    assign win = rr_scan(req, ptr_q);

    decoder_3x8 u_dec (
        .in  (gnt_idx),
        .en  (gnt_valid),
        .out (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            gnt_idx    <= '0;
            gnt_valid  <= 1'b0;
            hold_cnt_q <= '0;
            preempt    <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state_q)
                StIdle, StRelease: begin
                    if (win.found) begin
                        state_q    <= StGrant;
                        gnt_idx    <= win.idx;
                        gnt_valid  <= 1'b1;
                        hold_cnt_q <= '0;
                    end else begin
                        state_q   <= StIdle;
                        gnt_valid <= 1'b0;
                    end
                end
                StGrant: begin
                    // Release has priority over timeout, so preempt stays low when both coincide.
                    if (!req[gnt_idx]) begin
                        state_q   <= StRelease;
                        gnt_valid <= 1'b0;
                        ptr_q     <= gnt_idx + 3'd1;
                    end else if (hold_cnt_q == HoldLast && (req & ~gnt) != '0) begin
                        state_q   <= StRelease;
                        gnt_valid <= 1'b0;
                        ptr_q     <= gnt_idx + 3'd1;
                        preempt   <= 1'b1;
                    end else if (hold_cnt_q != HoldLast) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: a cycle model pushes expectations into a scoreboard
// queue at each edge; they are popped and compared on the following falling edge.
module tb_rr_arbiter_8;

    localparam int MaxHold = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    rr_arbiter_8 #(
        .MAX_HOLD (MaxHold),
        .HOLD_W   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state: 0 idle, 1 grant, 2 release.
    int         m_state;
    int         m_ptr;
    int         m_idx;
    int         m_cnt;
    logic       m_valid;
    logic       m_pre;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_valid = 1'b0; m_pre = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r);
        int   j;
        logic found;
        m_pre = 1'b0;
        if (m_state != 1) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                j = (m_ptr + k) % 8;
                if (!found && r[j]) begin
                    found = 1'b1;
                    m_idx = j;
                end
            end
            if (found) begin
                m_state = 1; m_valid = 1'b1; m_cnt = 0;
            end else begin
                m_state = 0; m_valid = 1'b0;
            end
        end else if (!r[m_idx]) begin
            m_state = 2; m_valid = 1'b0; m_ptr = (m_idx + 1) % 8;
        end else if (m_cnt == MaxHold - 1 && (r & ~(8'h01 << m_idx)) != 8'h00) begin
            m_state = 2; m_valid = 1'b0; m_ptr = (m_idx + 1) % 8; m_pre = 1'b1;
        end else if (m_cnt < MaxHold - 1) begin
            m_cnt++;
        end
    endtask

    // Drive req from a falling edge, model the rising edge, compare on the next falling edge.
    task automatic cycle(input logic [7:0] r);
        exp_t e;
        req = r;
        @(posedge clk);
        model_step(r);
        e.gnt   = m_valid ? (8'h01 << m_idx) : 8'h00;
        e.idx   = 3'(m_idx);
        e.valid = m_valid;
        e.pre   = m_pre;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        check("gnt", {24'd0, gnt}, {24'd0, e.gnt});
        check("gnt_valid", {31'd0, gnt_valid}, {31'd0, e.valid});
        check("preempt", {31'd0, preempt}, {31'd0, e.pre});
        if (e.valid) check("gnt_idx", {29'd0, gnt_idx}, {29'd0, e.idx});
        check("onehot", {31'd0, $countones(gnt) <= 1}, 32'd1);
    endtask

    // Entered on a falling edge; reset falls between edges and gnt must drop at once.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_gnt", {24'd0, gnt}, 32'd0);
        check("rst_valid", {31'd0, gnt_valid}, 32'd0);
        check("rst_idx", {29'd0, gnt_idx}, 32'd0);
        check("rst_preempt", {31'd0, preempt}, 32'd0);
        model_reset();
        req = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] g_log [18];
        logic       p_log [18];
        int         owners[$];
        int         gap;
        logic       prev_valid;
        int         pre_cnt;

        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        @(negedge clk);
        reset_pulse();

        // Idle, then a single requester.
        for (int i = 0; i < 5; i++) cycle(8'h00);
        check("idle_gnt", {24'd0, gnt}, 32'd0);
        cycle(8'h04);
        check("single_gnt", {24'd0, gnt}, 32'h04);
        check("single_idx", {29'd0, gnt_idx}, 32'd2);
        cycle(8'h00);
        check("single_drop", {24'd0, gnt}, 32'd0);
        cycle(8'h00);
        check("single_idle", {31'd0, gnt_valid}, 32'd0);

        // Rotation: everyone requests, each owner drops after two grant cycles.
        reset_pulse();
        gap = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < 40 && owners.size() < 9; i++) begin
            r = 8'hFF;
            if (m_state == 1 && m_cnt == 1) r[m_idx] = 1'b0;
            cycle(r);
            if (gnt_valid && !prev_valid) begin
                owners.push_back(int'(gnt_idx));
                if (owners.size() > 1) check("rot_gap", gap, 32'd1);
                gap = 0;
            end else if (!gnt_valid) begin
                gap++;
            end
            prev_valid = gnt_valid;
        end
        check("rot_count", owners.size(), 32'd9);
        for (int i = 0; i < owners.size(); i++) check("rot_order", owners[i], i % 8);

        // Timeout: owner 0 never releases while 1 waits.
        reset_pulse();
        for (int i = 0; i < 18; i++) begin
            cycle(8'h03);
            g_log[i] = gnt;
            p_log[i] = preempt;
        end
        pre_cnt = 0;
        for (int i = 0; i < 18; i++) if (p_log[i]) pre_cnt++;
        check("to_first", {24'd0, g_log[0]}, 32'h01);
        check("to_last", {24'd0, g_log[15]}, 32'h01);
        check("to_gap", {24'd0, g_log[16]}, 32'h00);
        check("to_pre", {31'd0, p_log[16]}, 32'd1);
        check("to_next", {24'd0, g_log[17]}, 32'h02);
        check("to_pre_once", pre_cnt, 32'd1);

        // Lone owner is never preempted.
        reset_pulse();
        pre_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            cycle(8'h01);
            if (preempt) pre_cnt++;
        end
        check("lone_pre", pre_cnt, 32'd0);
        check("lone_gnt", {24'd0, gnt}, 32'h01);

        // Release coincides with timeout: release wins.
        reset_pulse();
        for (int i = 0; i < 16; i++) cycle(8'h03);
        cycle(8'h02);
        check("sim_pre", {31'd0, preempt}, 32'd0);
        check("sim_gap", {24'd0, gnt}, 32'd0);
        cycle(8'h02);
        check("sim_next", {24'd0, gnt}, 32'h02);

        // Async reset mid-grant restarts arbitration from pointer 0.
        reset_pulse();
        cycle(8'h04);
        cycle(8'h04);
        cycle(8'h00);
        cycle(8'h00);
        cycle(8'h80);
        cycle(8'h80);
        check("pre_rst_gnt", {24'd0, gnt}, 32'h80);
        reset_pulse();
        cycle(8'h81);
        check("post_rst_gnt", {24'd0, gnt}, 32'h01);
        cycle(8'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
